multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL provide parameter MEM_WAIT, default 0: 1 = FSM waits on mem_ready in memory states; 0 = mem_ready ignored, treated as 1.
REQ-002 SHALL provide parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 SHALL provide parameter ALU_W, default 4: width of ALUControl.
REQ-004 Port: clk  in  1  single clock; all state changes on the rising edge.
REQ-005 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port: opcode  in  7  instruction opcode; funct3  in  3; funct7  in  7.
REQ-007 Port: Zero  in  1  ALU result == 0; less  in  1  ALU signed less-than.
REQ-008 Port: mem_ready  in  1  memory access completes this cycle.
REQ-009 Port: PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc  out  1 each  datapath enables and select.
REQ-010 Port: ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  datapath mux selects.
REQ-011 Port: ALUControl  out  ALU_W  ALU operation; state  out  4  current FSM state (debug).
REQ-012 Port: illegal  out  1  one-cycle pulse on an unsupported opcode; retired  out  CNT_W  instruction count.

Function
REQ-013 SHALL implement Moore FSM states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
REQ-014 Transitions:
- FETCH->DECODE.
- DECODE by opcode: 0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1100011->BRANCH; 1101111->JAL; other->FETCH with illegal=1.
- MEMADR->MEMREAD for opcode 0000011, else MEMWRITE.
- MEMREAD->MEMWB.
- EXECR/EXECI->ALUWB.
- JAL->ALUWB.
- MEMWB/MEMWRITE/ALUWB/BRANCH->FETCH.
REQ-015 If MEM_WAIT=1, FSM SHALL hold in FETCH, MEMREAD or MEMWRITE until mem_ready=1; in FETCH, IRWrite and PCWrite SHALL assert only in the cycle mem_ready=1.
REQ-016 MemWrite SHALL be 1 in every MEMWRITE cycle, including wait cycles.
REQ-017 Per-state outputs; unlisted signals are 0:
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALU add, ResultSrc=10, PCWrite=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALU add.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALU add.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALU per REQ-019.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALU per REQ-019 with funct7 ignored.
- ALUWB: RegWrite=1.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALU sub.
- JAL: ALUSrcA=01, ALUSrcB=10, ALU add, PCWrite=1.
REQ-018 In BRANCH, PCWrite SHALL be 1 when the branch is taken:
- funct3 000 (beq): taken if Zero.
- 001 (bne): taken if !Zero.
- 100 (blt): taken if less.
- 101 (bge): taken if !less.
- other funct3: not taken.
REQ-019 ALUControl encodings:
- add 0000.
- sub 0001, for funct3 000 with funct7[5]=1 in EXECR only.
- and 0010 for funct3 111.
- or 0011 for funct3 110.
- xor 0100 for funct3 100.
- slt 0101 for funct3 010.
- any other funct3: 0000.
- The 4-bit code SHALL be zero-extended to ALU_W.
REQ-020 ImmSrc SHALL be combinational from opcode in all states: I/load 00, store 01, branch 10, jal 11, other 00.
REQ-021 retired SHALL increment by 1 on every transition from MEMWB, MEMWRITE, ALUWB or BRANCH into FETCH, and SHALL wrap from all-ones to 0.
REQ-022 Illegal-opcode return SHALL NOT increment retired.

Reset
REQ-023 With rst_n=0 at a rising edge: state<=FETCH, retired<=0, illegal<=0.
REQ-024 While rst_n=0, PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0.
REQ-025 Reset asserted mid-instruction (e.g. in MEMWRITE) SHALL abort the instruction with no further writes; the first post-reset cycle SHALL be FETCH.

Verification
REQ-026 add (0110011/000/0000000), MEM_WAIT=0 -> states FETCH, DECODE, EXECR, ALUWB, FETCH; ALUControl=0000 in EXECR; RegWrite=1 only in ALUWB; retired 0->1.
REQ-027 lw with MEM_WAIT=1, mem_ready low for 3 cycles in MEMREAD -> 3 extra MEMREAD cycles, then MEMWB with ResultSrc=01, RegWrite=1; instruction takes 5+3 cycles.
REQ-028 sw with MEM_WAIT=1, mem_ready low for 2 cycles -> MemWrite=1 for 3 consecutive cycles, ImmSrc=01, RegWrite=0 throughout.
REQ-029 beq with Zero=1 -> PCWrite=1 in BRANCH; bne with Zero=1 -> PCWrite=0; blt with less=1 -> PCWrite=1; bge with less=1 -> PCWrite=0.
REQ-030 opcode 1111111 -> DECODE->FETCH, illegal=1 for exactly 1 cycle, retired unchanged; then jal -> ImmSrc=11, PCWrite=1 in JAL, RegWrite=1 in ALUWB.
REQ-031 CNT_W=2: retire 5 instructions -> retired sequence 1, 2, 3, 0, 1; rst_n=0 during MEMWRITE -> MemWrite=0 at once and state=FETCH after the edge.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
//
// Moore-style control FSM for a multicycle RISC-V-like datapath. Steps each
// instruction through FETCH, DECODE and an opcode-dependent sequence of
// execute/memory/writeback states, drives the datapath enables and mux
// selects from the current state, and counts retired instructions.
//
// Parameters:
//   MEM_WAIT - 1: FETCH/MEMREAD/MEMWRITE stall until mem_ready; 0: mem_ready
//              ignored (treated as 1)
//   CNT_W    - width of the retired-instruction counter
//   ALU_W    - width of ALUControl (4-bit code is zero-extended)
//
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   opcode/funct3/funct7  - instruction fields
//   Zero, less            - ALU flags for branch resolution
//   mem_ready             - memory access completes this cycle
//   PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc        - enables / select
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc                  - 2-bit mux selects
//   ALUControl            - ALU operation
//   state                 - current FSM state (debug)
//   illegal               - one-cycle pulse in the FETCH that follows a
//                           DECODE of an unsupported opcode
//   retired               - retired-instruction count (wraps)
//
// State encoding on the debug port: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3,
// MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10.
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 32,
  parameter int ALU_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             Zero,
  input  logic             less,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             AdrSrc,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [ALU_W-1:0] ALUControl,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;
  logic             mem_ok;
  logic             branch_taken;
  logic [3:0]       alu_sel;

  // Only funct7[5] matters (sub vs add in register ops).
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // With MEM_WAIT=0 every memory access is assumed to finish in one cycle.
  assign mem_ok = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic sub_ok);
    case (f3)
      3'b000:  return sub_ok ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b100:  return ALU_XOR;
      3'b010:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  always_comb begin
    case (funct3)
      3'b000:  branch_taken = Zero;
      3'b001:  branch_taken = ~Zero;
      3'b100:  branch_taken = less;
      3'b101:  branch_taken = ~less;
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state logic. retire marks every transition that completes an
  // instruction; the illegal-opcode return to FETCH deliberately does not.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      FETCH:    if (mem_ok) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_R:              state_d = EXECR;
          OP_I:              state_d = EXECI;
          OP_BR:             state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR:   state_d = (opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (mem_ok) state_d = MEMWB;
      MEMWRITE: begin
        if (mem_ok) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      EXECR, EXECI, JAL: state_d = ALUWB;
      MEMWB, ALUWB, BRANCH: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      default:  state_d = FETCH;
    endcase
    retired_d = retire ? retired_q + CNT_ONE : retired_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Per-state outputs; anything a state does not set stays 0.
  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_sel   = ALU_ADD;
    case (state_q)
      FETCH: begin
        // Instruction latch and PC+4 only on the cycle the fetch completes.
        IRWrite   = mem_ok;
        PCWrite   = mem_ok;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        alu_sel = alu_decode(funct3, funct7[5]);
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_sel = alu_decode(funct3, 1'b0);
      end
      ALUWB:    RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA = 2'b10;
        alu_sel = ALU_SUB;
        PCWrite = branch_taken;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    // Reset kills all architectural writes immediately, even mid-instruction.
    if (!rst_n) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    case (opcode)
      OP_STORE: ImmSrc = 2'b01;
      OP_BR:    ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  assign ALUControl = ALU_W'(alu_sel);
  assign state      = state_q;
  assign illegal    = illegal_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// Bench for multicycle_control_unit. Two instances: dut0 (MEM_WAIT=0,
// CNT_W=32) and dut1 (MEM_WAIT=1, CNT_W=2); only one is out of reset at a
// time while they share the input stimulus. For every instruction the model
// expands the instruction rules into an expected per-cycle trace (state,
// control outputs, illegal, retired, mem_ready to drive), which is then
// replayed against the active DUT cycle by cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3,
                 S_MEMWB = 4, S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7,
                 S_ALUWB = 8, S_BRANCH = 9, S_JAL = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n0, rst_n1;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       Zero, less, mem_ready;

  logic       d0_pcw, d0_irw, d0_mw, d0_rw, d0_adr, d0_ill;
  logic [1:0] d0_res, d0_sa, d0_sb, d0_imm;
  logic [3:0] d0_alu, d0_state;
  logic [31:0] d0_ret;
  logic       d1_pcw, d1_irw, d1_mw, d1_rw, d1_adr, d1_ill;
  logic [1:0] d1_res, d1_sa, d1_sb, d1_imm;
  logic [3:0] d1_alu, d1_state;
  logic [1:0] d1_ret;

  multicycle_control_unit #(.MEM_WAIT(0), .CNT_W(32), .ALU_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n0), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .less(less), .mem_ready(mem_ready),
    .PCWrite(d0_pcw), .IRWrite(d0_irw), .MemWrite(d0_mw), .RegWrite(d0_rw),
    .AdrSrc(d0_adr), .ResultSrc(d0_res), .ALUSrcA(d0_sa), .ALUSrcB(d0_sb),
    .ImmSrc(d0_imm), .ALUControl(d0_alu), .state(d0_state), .illegal(d0_ill),
    .retired(d0_ret)
  );

  multicycle_control_unit #(.MEM_WAIT(1), .CNT_W(2), .ALU_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n1), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .less(less), .mem_ready(mem_ready),
    .PCWrite(d1_pcw), .IRWrite(d1_irw), .MemWrite(d1_mw), .RegWrite(d1_rw),
    .AdrSrc(d1_adr), .ResultSrc(d1_res), .ALUSrcA(d1_sa), .ALUSrcB(d1_sb),
    .ImmSrc(d1_imm), .ALUControl(d1_alu), .state(d1_state), .illegal(d1_ill),
    .retired(d1_ret)
  );

  bit phase; // 0: dut0 active, 1: dut1 active
  logic [3:0]  obs_state;
  logic [16:0] obs_ctrl;
  logic        obs_ill;
  logic [31:0] obs_ret;
  assign obs_state = phase ? d1_state : d0_state;
  assign obs_ill   = phase ? d1_ill : d0_ill;
  assign obs_ret   = phase ? {30'd0, d1_ret} : d0_ret;
  assign obs_ctrl  = phase ?
    {d1_pcw, d1_irw, d1_mw, d1_rw, d1_adr, d1_res, d1_sa, d1_sb, d1_imm, d1_alu} :
    {d0_pcw, d0_irw, d0_mw, d0_rw, d0_adr, d0_res, d0_sa, d0_sb, d0_imm, d0_alu};

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]  st;
    logic        pcw, irw, mw, rw, adr;
    logic [1:0]  res, sa, sb, imm;
    logic [3:0]  alu;
    logic        ill;
    logic        mr;
    logic [31:0] ret;
  } cyc_t;

  cyc_t       q[$];
  bit         mem_wait_m;
  int         ret_cnt;
  bit         pend_ill;
  logic [1:0] cur_imm;
  int         force_w = -1;

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic [6:0] f7, input bit is_r);
    case (f3)
      3'd0:    return (is_r && f7[5]) ? 4'd1 : 4'd0;
      3'd7:    return 4'd2;
      3'd6:    return 4'd3;
      3'd4:    return 4'd4;
      3'd2:    return 4'd5;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [1:0] ref_imm(input logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
    if (op == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit ref_taken(input logic [2:0] f3, input bit z, input bit lt);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return lt;
      3'd5:    return !lt;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
           op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111;
  endfunction

  function automatic cyc_t mk(input int st, input bit pcw, input bit irw, input bit mw,
                              input bit rw, input bit adr, input logic [1:0] res,
                              input logic [1:0] sa, input logic [1:0] sb,
                              input logic [3:0] alu, input bit mr);
    cyc_t c;
    c = '0;
    c.st = st[3:0]; c.pcw = pcw; c.irw = irw; c.mw = mw; c.rw = rw; c.adr = adr;
    c.res = res; c.sa = sa; c.sb = sb; c.alu = alu; c.mr = mr;
    return c;
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // mem_ready on the completing cycle of a memory state
  function automatic bit done_mr();
    return mem_wait_m ? 1'b1 : rnd();
  endfunction

  function automatic int n_wait(input bit is_fetch);
    if (!mem_wait_m) return 0;
    if (force_w >= 0) return is_fetch ? 0 : force_w;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic push(input cyc_t c);
    c.imm = cur_imm;
    c.ill = pend_ill;
    pend_ill = 1'b0;
    c.ret = phase ? (ret_cnt & 32'h3) : ret_cnt;
    q.push_back(c);
  endtask

  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input bit z, input bit lt);
    int w;
    cur_imm = ref_imm(op);
    w = n_wait(1);
    for (int i = 0; i < w; i++) push(mk(S_FETCH, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'd0, 1'b0));
    push(mk(S_FETCH, 1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 4'd0, done_mr()));
    push(mk(S_DECODE, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'd0, rnd()));
    case (op)
      7'b0000011: begin
        push(mk(S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, rnd()));
        w = n_wait(0);
        for (int i = 0; i < w; i++) push(mk(S_MEMREAD, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0, 1'b0));
        push(mk(S_MEMREAD, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0, done_mr()));
        push(mk(S_MEMWB, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 4'd0, rnd()));
      end
      7'b0100011: begin
        push(mk(S_MEMADR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, rnd()));
        w = n_wait(0);
        for (int i = 0; i < w; i++) push(mk(S_MEMWRITE, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0, 1'b0));
        push(mk(S_MEMWRITE, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0, done_mr()));
      end
      7'b0110011: begin
        push(mk(S_EXECR, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ref_alu(f3, f7, 1), rnd()));
        push(mk(S_ALUWB, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'd0, rnd()));
      end
      7'b0010011: begin
        push(mk(S_EXECI, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ref_alu(f3, f7, 0), rnd()));
        push(mk(S_ALUWB, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'd0, rnd()));
      end
      7'b1100011:
        push(mk(S_BRANCH, ref_taken(f3, z, lt), 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd1, rnd()));
      7'b1101111: begin
        push(mk(S_JAL, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'd0, rnd()));
        push(mk(S_ALUWB, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 4'd0, rnd()));
      end
      default: ;
    endcase
    if (is_legal(op)) ret_cnt++;
    else pend_ill = 1'b1;
  endtask

  // Replays the queued trace; entered and left at posedge+1.
  task automatic drain(input bit abort_mw);
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      mem_ready = c.mr;
      #1;
      check_eq("state", 32'(obs_state), 32'(c.st));
      check_eq("ctrl", 32'(obs_ctrl),
               32'({c.pcw, c.irw, c.mw, c.rw, c.adr, c.res, c.sa, c.sb, c.imm, c.alu}));
      check_eq("illegal", 32'(obs_ill), 32'(c.ill));
      check_eq("retired", obs_ret, c.ret);
      if (abort_mw && c.st == 4'(S_MEMWRITE)) begin
        q.delete();
        rst_n1 = 1'b0;
        #1;
        check_eq("rst_memwrite", 32'(d1_mw), 32'd0);
        check_eq("rst_wen", 32'({d1_pcw, d1_irw, d1_rw}), 32'd0);
        @(posedge clk);
        #1;
        check_eq("rst_state", 32'(d1_state), 32'(S_FETCH));
        check_eq("rst_retired", 32'(d1_ret), 32'd0);
        check_eq("rst_illegal", 32'(d1_ill), 32'd0);
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input bit z, input bit lt, input bit abort_mw);
    int n;
    opcode = op; funct3 = f3; funct7 = f7; Zero = z; less = lt;
    build(op, f3, f7, z, lt);
    n = q.size();
    drain(abort_mw);
    $display("dut%0d instr op=%b f3=%0d f7=%b Zero=%0d less=%0d cycles=%0d model_retired=%0d",
             phase, op, f3, f7, z, lt, n, ret_cnt);
  endtask

  task automatic run_random(input int count);
    logic [6:0] ops [7];
    logic [6:0] op;
    int k;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0000000};
    for (int i = 0; i < count; i++) begin
      k = int'($urandom_range(0, 6));
      op = ops[k];
      if (k == 6) begin
        do op = 7'($urandom_range(0, 127)); while (is_legal(op));
      end
      run_instr(op, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)),
                rnd(), rnd(), 1'b0);
    end
  endtask

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0; phase = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0; Zero = 1'b0; less = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    check_eq("reset_wen0", 32'({d0_pcw, d0_irw, d0_mw, d0_rw}), 32'd0);
    check_eq("reset_wen1", 32'({d1_pcw, d1_irw, d1_mw, d1_rw}), 32'd0);
    @(posedge clk);
    #1;
    check_eq("reset_state0", 32'(d0_state), 32'(S_FETCH));
    check_eq("reset_state1", 32'(d1_state), 32'(S_FETCH));
    check_eq("reset_retired0", d0_ret, 32'd0);
    check_eq("reset_retired1", 32'(d1_ret), 32'd0);
    check_eq("reset_illegal", 32'({d0_ill, d1_ill}), 32'd0);

    // dut0: MEM_WAIT=0
    mem_wait_m = 1'b0; ret_cnt = 0; pend_ill = 1'b0;
    rst_n0 = 1'b1;
    run_instr(7'b0110011, 3'd0, 7'b0000000, 1'b0, 1'b0, 1'b0); // add
    run_instr(7'b1100011, 3'd0, 7'd0, 1'b1, 1'b0, 1'b0);       // beq taken
    run_instr(7'b1100011, 3'd1, 7'd0, 1'b1, 1'b0, 1'b0);       // bne not taken
    run_instr(7'b1100011, 3'd4, 7'd0, 1'b0, 1'b1, 1'b0);       // blt taken
    run_instr(7'b1100011, 3'd5, 7'd0, 1'b0, 1'b1, 1'b0);       // bge not taken
    run_instr(7'b1111111, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);       // illegal
    run_instr(7'b1101111, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0);       // jal
    run_instr(7'b0110011, 3'd0, 7'b0100000, 1'b0, 1'b0, 1'b0); // sub
    run_instr(7'b0010011, 3'd0, 7'b0100000, 1'b0, 1'b0, 1'b0); // addi, funct7 ignored
    run_random(60);

    // dut1: MEM_WAIT=1, CNT_W=2
    rst_n0 = 1'b0; rst_n1 = 1'b1; phase = 1'b1;
    mem_wait_m = 1'b1; ret_cnt = 0; pend_ill = 1'b0;
    force_w = 3;
    run_instr(7'b0000011, 3'd2, 7'd0, 1'b0, 1'b0, 1'b0);       // lw, 3 wait cycles
    force_w = 2;
    run_instr(7'b0100011, 3'd2, 7'd0, 1'b0, 1'b0, 1'b0);       // sw, 2 wait cycles
    force_w = -1;
    run_random(60);
    force_w = 3;
    run_instr(7'b0100011, 3'd2, 7'd0, 1'b0, 1'b0, 1'b1);       // sw aborted by reset

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
